// File: rtl/mips_single_cycle_core.sv
// Single-cycle 32-bit MIPS-subset core: fetch, decode, ALU, memory, write-back.
// A loader port fills instruction memory through the PC before execution.
module mips_single_cycle_core #(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] WriteData,
  input  logic        WriteEnable,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic [31:0] FromMUXtoREG,
  output logic [31:0] ALUresult,
  output logic [11:0] ControlLines
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] regs [32];
  logic [31:0] dmem [DMEM_DEPTH];

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [31:0] imm;
  logic [31:0] imm_sext;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] dmem_rd;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [4:0]  wa;
  logic [3:0]  alu_ctl;
  logic        reg_dst;
  logic        reg_write;
  logic        branch;
  logic        mem_write;
  logic        mem_to_reg;
  logic        shift;
  logic        alu_src;
  logic        jump;
  logic        zero;

  assign instr = imem[pc[IAW+1:2]];
  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];

  assign reg_dst    = ControlLines[0];
  assign reg_write  = ControlLines[1];
  assign branch     = ControlLines[2];
  assign mem_write  = ControlLines[3];
  assign mem_to_reg = ControlLines[4];
  assign alu_ctl    = ControlLines[8:5];
  assign shift      = ControlLines[9];
  assign alu_src    = ControlLines[10];
  assign jump       = ControlLines[11];

  // Control decode; unknown opcodes/functs yield an all-zero word (NOP)
  always_comb begin
    ControlLines = 12'h000;
    unique case (op)
      6'h00: begin
        unique case (funct)
          6'h20:   ControlLines = 12'h043;
          6'h22:   ControlLines = 12'h0C3;
          6'h24:   ControlLines = 12'h003;
          6'h25:   ControlLines = 12'h023;
          6'h27:   ControlLines = 12'h183;
          6'h2A:   ControlLines = 12'h0E3;
          6'h00:   ControlLines = 12'h303;
          6'h02:   ControlLines = 12'h323;
          default: ControlLines = 12'h000;
        endcase
      end
      6'h08:   ControlLines = 12'h442;
      6'h0C:   ControlLines = 12'h402;
      6'h0D:   ControlLines = 12'h422;
      6'h23:   ControlLines = 12'h452;
      6'h2B:   ControlLines = 12'h448;
      6'h04:   ControlLines = 12'h0C4;
      6'h02:   ControlLines = 12'h800;
      default: ControlLines = 12'h000;
    endcase
  end

  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm = (op == 6'h0C || op == 6'h0D) ?
               {16'h0000, instr[15:0]} : imm_sext;

  assign ReadData1 = (rs == 5'd0) ? 32'h0 : regs[rs];
  assign ReadData2 = (rt == 5'd0) ? 32'h0 : regs[rt];

  assign alu_a = shift ? {27'h0, shamt} : ReadData1;
  assign alu_b = alu_src ? imm : ReadData2;

  // ALU; shifts move the B operand (rt) by the A operand (shamt)
  always_comb begin
    ALUresult = 32'h0;
    unique case (alu_ctl)
      4'b0000: ALUresult = alu_a & alu_b;
      4'b0001: ALUresult = alu_a | alu_b;
      4'b0010: ALUresult = alu_a + alu_b;
      4'b0110: ALUresult = alu_a - alu_b;
      4'b0111: ALUresult = {31'h0, $signed(alu_a) < $signed(alu_b)};
      4'b1100: ALUresult = ~(alu_a | alu_b);
      4'b1000: ALUresult = alu_b << alu_a[4:0];
      4'b1001: ALUresult = alu_b >> alu_a[4:0];
      default: ALUresult = 32'h0;
    endcase
  end

  assign zero = (ALUresult == 32'h0);

  assign dmem_rd      = dmem[ALUresult[DAW+1:2]];
  assign FromMUXtoREG = mem_to_reg ? dmem_rd : ALUresult;
  assign wa           = reg_dst ? rd : rt;
  assign pc_plus4     = pc + 32'd4;

  // Next-PC select; the loader just walks forward word by word
  always_comb begin
    pc_next = pc_plus4;
    if (!WriteEnable) begin
      if (jump)
        pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
      else if (branch && zero)
        pc_next = pc_plus4 + {imm_sext[29:0], 2'b00};
    end
  end

  // Program counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) pc <= 32'h0;
    else       pc <= pc_next;
  end

  // Instruction memory loader; contents survive reset
  always_ff @(posedge Clk) begin
    if (WriteEnable && !Reset)
      imem[pc[IAW+1:2]] <= WriteData;
  end

  // Register file write-back; $0 is never written
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (!WriteEnable && reg_write && wa != 5'd0) begin
      regs[wa] <= FromMUXtoREG;
    end
  end

  // Data memory store of rt
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= 32'h0;
    end else if (!WriteEnable && mem_write) begin
      dmem[ALUresult[DAW+1:2]] <= ReadData2;
    end
  end

endmodule

// File: tb/tb_mips_single_cycle_core.sv
// Directed bench for the single-cycle MIPS core.
// Programs are loaded through the loader port, then run one clock per instruction.
module tb_mips_single_cycle_core;

  logic        Clk;
  logic        Reset;
  logic [31:0] WriteData;
  logic        WriteEnable;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] FromMUXtoREG;
  logic [31:0] ALUresult;
  logic [11:0] ControlLines;

  int checks = 0;
  int errors = 0;

  logic [31:0] prog [16];
  int          prog_n;

  mips_single_cycle_core dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .WriteData    (WriteData),
    .WriteEnable  (WriteEnable),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
    .FromMUXtoREG (FromMUXtoREG),
    .ALUresult    (ALUresult),
    .ControlLines (ControlLines)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
  endtask

  task automatic load_imem();
    do_reset();
    for (int i = 0; i < prog_n; i++) begin
      WriteEnable = 1'b1;
      WriteData   = prog[i];
      @(posedge Clk);
      #1;
    end
    WriteEnable = 1'b0;
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_load_run();
    prog[0] = 32'h20010005;
    prog[1] = 32'h20020007;
    prog[2] = 32'h00221820;
    prog_n  = 3;
    load_imem();
    checks++; if (dut.pc !== 32'd12) begin errors++; $display("FAIL loader_pc got %h exp %h", dut.pc, 32'd12); end
    checks++; if (dut.regs[1] !== 32'd0) begin errors++; $display("FAIL loader_no_regwrite got %h exp %h", dut.regs[1], 32'd0); end
    do_reset();
    checks++; if (dut.pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp %h", dut.pc, 32'd0); end
    checks++; if (ControlLines !== 12'h442) begin errors++; $display("FAIL reset_decode got %h exp %h", ControlLines, 12'h442); end
    checks++; if (ALUresult !== 32'd5) begin errors++; $display("FAIL addi_alu got %h exp %h", ALUresult, 32'd5); end
    step();
    step();
    checks++; if (ReadData1 !== 32'd5) begin errors++; $display("FAIL add_rd1 got %h exp %h", ReadData1, 32'd5); end
    checks++; if (ReadData2 !== 32'd7) begin errors++; $display("FAIL add_rd2 got %h exp %h", ReadData2, 32'd7); end
    checks++; if (ALUresult !== 32'd12) begin errors++; $display("FAIL add_alu got %h exp %h", ALUresult, 32'd12); end
    checks++; if (ControlLines !== 12'h043) begin errors++; $display("FAIL add_ctl got %h exp %h", ControlLines, 12'h043); end
    step();
    checks++; if (dut.regs[3] !== 32'd12) begin errors++; $display("FAIL add_wb got %h exp %h", dut.regs[3], 32'd12); end
  endtask

  task automatic test_store_load();
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd100);
    prog[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
    prog[2] = enc_i(6'h23, 5'd0, 5'd4, 16'd8);
    prog_n  = 3;
    load_imem();
    do_reset();
    step();
    checks++; if (ControlLines !== 12'h448) begin errors++; $display("FAIL sw_ctl got %h exp %h", ControlLines, 12'h448); end
    checks++; if (ALUresult !== 32'd8) begin errors++; $display("FAIL sw_alu got %h exp %h", ALUresult, 32'd8); end
    checks++; if (ReadData2 !== 32'd100) begin errors++; $display("FAIL sw_data got %h exp %h", ReadData2, 32'd100); end
    step();
    checks++; if (ControlLines !== 12'h452) begin errors++; $display("FAIL lw_ctl got %h exp %h", ControlLines, 12'h452); end
    checks++; if (FromMUXtoREG !== 32'd100) begin errors++; $display("FAIL lw_wb got %h exp %h", FromMUXtoREG, 32'd100); end
    step();
    checks++; if (dut.regs[4] !== 32'd100) begin errors++; $display("FAIL lw_reg got %h exp %h", dut.regs[4], 32'd100); end
    checks++; if (dut.dmem[2] !== 32'd100) begin errors++; $display("FAIL sw_mem got %h exp %h", dut.dmem[2], 32'd100); end
  endtask

  task automatic test_branch();
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
    prog[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd3);
    prog[2] = enc_i(6'h04, 5'd1, 5'd2, 16'd2);
    prog[3] = 32'h0;
    prog[4] = 32'h0;
    prog[5] = 32'h0;
    prog_n  = 6;
    load_imem();
    do_reset();
    step();
    step();
    checks++; if (ControlLines !== 12'h0C4) begin errors++; $display("FAIL beq_ctl got %h exp %h", ControlLines, 12'h0C4); end
    checks++; if (ALUresult !== 32'd0) begin errors++; $display("FAIL beq_alu_eq got %h exp %h", ALUresult, 32'd0); end
    step();
    checks++; if (dut.pc !== 32'd20) begin errors++; $display("FAIL beq_taken_pc got %h exp %h", dut.pc, 32'd20); end
    prog[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd4);
    load_imem();
    do_reset();
    step();
    step();
    checks++; if (ALUresult !== 32'hFFFF_FFFF) begin errors++; $display("FAIL beq_alu_ne got %h exp %h", ALUresult, 32'hFFFF_FFFF); end
    step();
    checks++; if (dut.pc !== 32'd12) begin errors++; $display("FAIL beq_not_taken_pc got %h exp %h", dut.pc, 32'd12); end
  endtask

  task automatic test_shift_slt_zero();
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
    prog[1] = enc_r(5'd0, 5'd1, 5'd5, 5'd4, 6'h00);
    prog[2] = enc_i(6'h08, 5'd0, 5'd6, 16'hFFFF);
    prog[3] = enc_i(6'h08, 5'd0, 5'd7, 16'd1);
    prog[4] = enc_r(5'd6, 5'd7, 5'd8, 5'd0, 6'h2A);
    prog[5] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
    prog[6] = enc_r(5'd0, 5'd0, 5'd9, 5'd0, 6'h20);
    prog[7] = enc_i(6'h0D, 5'd0, 5'd10, 16'h8000);
    prog_n  = 8;
    load_imem();
    do_reset();
    step();
    checks++; if (ALUresult !== 32'd48) begin errors++; $display("FAIL sll_alu got %h exp %h", ALUresult, 32'd48); end
    checks++; if (ControlLines !== 12'h303) begin errors++; $display("FAIL sll_ctl got %h exp %h", ControlLines, 12'h303); end
    step();
    step();
    step();
    checks++; if (ALUresult !== 32'd1) begin errors++; $display("FAIL slt_alu got %h exp %h", ALUresult, 32'd1); end
    checks++; if (ControlLines !== 12'h0E3) begin errors++; $display("FAIL slt_ctl got %h exp %h", ControlLines, 12'h0E3); end
    step();
    checks++; if (ALUresult !== 32'd9) begin errors++; $display("FAIL addi_r0_alu got %h exp %h", ALUresult, 32'd9); end
    step();
    checks++; if (ReadData1 !== 32'd0) begin errors++; $display("FAIL r0_read got %h exp %h", ReadData1, 32'd0); end
    checks++; if (dut.regs[0] !== 32'd0) begin errors++; $display("FAIL r0_reg got %h exp %h", dut.regs[0], 32'd0); end
    step();
    checks++; if (ALUresult !== 32'h0000_8000) begin errors++; $display("FAIL ori_zext got %h exp %h", ALUresult, 32'h0000_8000); end
    checks++; if (ControlLines !== 12'h422) begin errors++; $display("FAIL ori_ctl got %h exp %h", ControlLines, 12'h422); end
  endtask

  task automatic test_jump_illegal();
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    prog[1] = 32'hFC22_1800;
    prog[2] = 32'h0800_0010;
    prog_n  = 3;
    load_imem();
    do_reset();
    step();
    checks++; if (ControlLines !== 12'h000) begin errors++; $display("FAIL illegal_ctl got %h exp %h", ControlLines, 12'h000); end
    step();
    checks++; if (dut.pc !== 32'd8) begin errors++; $display("FAIL illegal_pc got %h exp %h", dut.pc, 32'd8); end
    checks++; if (dut.regs[3] !== 32'd0) begin errors++; $display("FAIL illegal_nowrite got %h exp %h", dut.regs[3], 32'd0); end
    checks++; if (dut.regs[1] !== 32'd1) begin errors++; $display("FAIL illegal_keep got %h exp %h", dut.regs[1], 32'd1); end
    checks++; if (ControlLines !== 12'h800) begin errors++; $display("FAIL j_ctl got %h exp %h", ControlLines, 12'h800); end
    step();
    checks++; if (dut.pc !== 32'h40) begin errors++; $display("FAIL j_pc got %h exp %h", dut.pc, 32'h40); end
  endtask

  task automatic test_async_reset();
    prog[0] = 32'h20010005;
    prog[1] = 32'h20020007;
    prog[2] = 32'h00221820;
    prog[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'd4);
    prog_n  = 4;
    load_imem();
    do_reset();
    step();
    step();
    step();
    @(posedge Clk);
    #2;
    checks++; if (dut.dmem[1] !== 32'd12) begin errors++; $display("FAIL pre_reset_mem got %h exp %h", dut.dmem[1], 32'd12); end
    #1;
    Reset = 1'b1;
    #1;
    checks++; if (dut.pc !== 32'd0) begin errors++; $display("FAIL async_pc got %h exp %h", dut.pc, 32'd0); end
    checks++; if (dut.regs[3] !== 32'd0) begin errors++; $display("FAIL async_reg got %h exp %h", dut.regs[3], 32'd0); end
    checks++; if (dut.dmem[1] !== 32'd0) begin errors++; $display("FAIL async_mem got %h exp %h", dut.dmem[1], 32'd0); end
    checks++; if (ControlLines !== 12'h442) begin errors++; $display("FAIL async_decode got %h exp %h", ControlLines, 12'h442); end
    #1;
    Reset = 1'b0;
    step();
    step();
    checks++; if (ReadData1 !== 32'd5) begin errors++; $display("FAIL rerun_rd1 got %h exp %h", ReadData1, 32'd5); end
    checks++; if (ALUresult !== 32'd12) begin errors++; $display("FAIL rerun_alu got %h exp %h", ALUresult, 32'd12); end
  endtask

  initial begin
    Reset       = 1'b1;
    WriteEnable = 1'b0;
    WriteData   = 32'h0;
    prog_n      = 0;
    for (int i = 0; i < 16; i++) prog[i] = 32'h0;
    #12;
    Reset = 1'b0;
    test_load_run();
    test_store_load();
    test_branch();
    test_shift_slt_zero();
    test_jump_illegal();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
